// File: rtl/fir_unr_mac_if.sv
// Window-in / samples-out bundle of the unrolled FIR MAC, together with the
// shadow-coefficient load port used by the control plane.
interface fir_unr_mac_if #(
    parameter int DWIDTH = 15,
    parameter int UNR    = 4,
    parameter int BUFLEN = 40,
    parameter int CWIDTH = 16,
    parameter int OWIDTH = 16
);
    logic [BUFLEN-1:0][DWIDTH-1:0] taps;
    logic                          taps_vld;
    logic                          coef_we;
    logic [5:0]                    coef_addr;
    logic [CWIDTH-1:0]             coef_data;
    logic                          coef_commit;
    logic [UNR-1:0][OWIDTH-1:0]    dout;
    logic                          dout_vld;
    logic                          sat_flag;

    modport master (
        output taps, taps_vld, coef_we, coef_addr, coef_data, coef_commit,
        input  dout, dout_vld, sat_flag
    );

    modport slave (
        input  taps, taps_vld, coef_we, coef_addr, coef_data, coef_commit,
        output dout, dout_vld, sat_flag
    );
endinterface

// File: rtl/fir_unr_mac.sv
// Unrolled FIR MAC: UNR outputs per clock from a BUFLEN-tap window, registered
// products, registered binary adder tree, then round/saturate (8 clocks total).
module fir_unr_mac #(
    parameter int DWIDTH = 15,
    parameter int UNR    = 4,
    parameter int NTAP   = 37,
    parameter int BUFLEN = 40,
    parameter int CWIDTH = 16,
    parameter int SHIFT  = 15,
    parameter int OWIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    fir_unr_mac_if.slave bus
);

    function automatic int nodes(input int lvl);
        return (NTAP + (1 << lvl) - 1) >> lvl;
    endfunction

    localparam int PW     = DWIDTH + CWIDTH;
    localparam int LEVELS = $clog2(NTAP);
    localparam int AW     = PW + LEVELS;
    localparam int PAD    = 2 * nodes(1);
    localparam int GROUPS = BUFLEN / UNR;
    localparam int CNTW   = $clog2(GROUPS + 1);
    localparam int LAT    = LEVELS + 2;

    localparam logic signed [AW-1:0] RND  = AW'(2 ** (SHIFT - 1));
    localparam logic signed [AW-1:0] OMAX = AW'(2 ** (OWIDTH - 1) - 1);
    localparam logic signed [AW-1:0] OMIN = AW'(-(2 ** (OWIDTH - 1)));

    if (BUFLEN != NTAP - 1 + UNR) begin : g_bad_window
        $error("fir_unr_mac: BUFLEN must equal NTAP-1+UNR");
    end

    typedef enum logic {FILL, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   fill_cnt, fill_cnt_d;
    logic              emit;

    logic signed [CWIDTH-1:0] shadow [NTAP];
    logic signed [CWIDTH-1:0] active [NTAP];

    // Tree arrays are padded to an even width so the pair reads below never
    // leave the array; padding entries are only ever reset, so they read as 0.
    logic signed [PW-1:0]     prod [UNR][PAD];
    logic signed [AW-1:0]     tree [LEVELS][UNR][PAD];
    logic [LAT-2:0]           vld_pipe;

    logic signed [AW-1:0]       rnd [UNR];
    logic [UNR-1:0][OWIDTH-1:0] sat_val;
    logic [UNR-1:0]             clip;

    logic [UNR-1:0][OWIDTH-1:0] dout_q;
    logic                       dout_vld_q;
    logic                       sat_q;

    // NOTE: both banks sit in flops rather than RAM, so a synchronous clear
    // is cheap and guarantees all-zero coefficients straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAP; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            // Out-of-range addresses never match any k, so they are dropped.
            for (int k = 0; k < NTAP; k++) begin
                if (bus.coef_we && bus.coef_addr == 6'(k))
                    shadow[k] <= bus.coef_data;
                if (bus.coef_commit)
                    active[k] <= (bus.coef_we && bus.coef_addr == 6'(k)) ?
                                 bus.coef_data : shadow[k];
            end
        end
    end

    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers sample pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            fill_cnt <= '0;
        end else begin
            state_q  <= state_d;
            fill_cnt <= fill_cnt_d;
        end
    end

    // NOTE: each combinational output is given a default before any branch,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt;
        if (state_q == FILL && bus.taps_vld) begin
            fill_cnt_d = fill_cnt + CNTW'(1);
            if (fill_cnt == CNTW'(GROUPS - 1))
                state_d = RUN;
        end
    end

    always_comb begin
        emit = 1'b0;
        if (bus.taps_vld)
            emit = (state_q == RUN) || (fill_cnt == CNTW'(GROUPS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < UNR; i++) begin
                for (int n = 0; n < PAD; n++) begin
                    prod[i][n] <= '0;
                    for (int l = 0; l < LEVELS; l++)
                        tree[l][i][n] <= '0;
                end
            end
        end else begin
            vld_pipe <= {vld_pipe[LAT-3:0], emit};
            for (int i = 0; i < UNR; i++) begin
                for (int k = 0; k < NTAP; k++)
                    prod[i][k] <= PW'($signed(bus.taps[i + k])) * PW'(active[k]);
                for (int n = 0; n < PAD / 2; n++)
                    if (n < nodes(1))
                        tree[0][i][n] <= AW'(prod[i][2 * n]) + AW'(prod[i][2 * n + 1]);
                for (int l = 1; l < LEVELS; l++)
                    for (int n = 0; n < PAD / 2; n++)
                        if (n < nodes(l + 1))
                            tree[l][i][n] <= tree[l - 1][i][2 * n] + tree[l - 1][i][2 * n + 1];
            end
        end
    end

    // Round half up, then clamp into the signed output range.
    always_comb begin
        clip    = '0;
        sat_val = '0;
        for (int i = 0; i < UNR; i++) begin
            rnd[i] = (tree[LEVELS - 1][i][0] + RND) >>> SHIFT;
            if (rnd[i] > OMAX) begin
                clip[i]    = 1'b1;
                sat_val[i] = OWIDTH'(OMAX);
            end else if (rnd[i] < OMIN) begin
                clip[i]    = 1'b1;
                sat_val[i] = OWIDTH'(OMIN);
            end else begin
                sat_val[i] = OWIDTH'(rnd[i]);
            end
        end
    end

    // Only emitted outputs may raise the sticky flag; bubbles carry stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            dout_q     <= sat_val;
            dout_vld_q <= vld_pipe[LAT-2];
            if (vld_pipe[LAT-2] && |clip)
                sat_q <= 1'b1;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_fir_unr_mac.sv
// Bench for fir_unr_mac: directed vectors, an arithmetic reference model and a
// per-cycle comparison of dout_vld, sat_flag and every valid dout lane.
module tb_fir_unr_mac;

    localparam int DW = 15;
    localparam int U  = 4;
    localparam int NT = 37;
    localparam int BL = 40;
    localparam int CW = 16;
    localparam int OW = 16;

    logic clk;
    logic rst;

    fir_unr_mac_if #(.DWIDTH(DW), .UNR(U), .BUFLEN(BL), .CWIDTH(CW), .OWIDTH(OW)) bus ();

    fir_unr_mac #(
        .DWIDTH(DW), .UNR(U), .NTAP(NT), .BUFLEN(BL),
        .CWIDTH(CW), .SHIFT(15), .OWIDTH(OW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int tv [BL];
    int got [$];

    // Reference state: coefficient banks, primed-group count, expected outputs
    // indexed by the clock edge after which they must be visible.
    int     mshadow [NT];
    int     mactive [NT];
    int     fills = 0;
    int     e = 0;
    bit     msat = 1'b0;
    bit     ev [16];
    bit     es [16];
    longint ed [16][U];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit v, input bit we = 1'b0, input int addr = 0,
                       input int data = 0, input bit cm = 1'b0, input bit r = 1'b0);
        @(negedge clk);
        for (int j = 0; j < BL; j++)
            bus.taps[j] = DW'(tv[j]);
        bus.taps_vld    = v;
        bus.coef_we     = we;
        bus.coef_addr   = 6'(addr);
        bus.coef_data   = CW'(data);
        bus.coef_commit = cm;
        rst             = r;
    endtask

    task automatic set_taps(input int val);
        for (int j = 0; j < BL; j++)
            tv[j] = val;
    endtask

    task automatic rand_taps();
        for (int j = 0; j < BL; j++)
            tv[j] = int'($urandom_range(8000)) - 4000;
    endtask

    // kind 0: constant, 1: ramp 100*k, 2: random. The last write shares its
    // cycle with the commit; two out-of-range writes go first.
    task automatic load(input int kind, input int val);
        cyc(1'b0, 1'b1, NT, 1234);
        cyc(1'b0, 1'b1, 63, -1234);
        for (int k = 0; k < NT; k++) begin
            int c;
            c = (kind == 0) ? val : (kind == 1) ? 100 * k : int'($urandom_range(8000)) - 4000;
            cyc(1'b0, 1'b1, k, c, k == NT - 1);
        end
    endtask

    task automatic drain();
        repeat (12) cyc(1'b0);
    endtask

    // Reference model, evaluated on each rising edge with the inputs it sampled.
    initial begin
        foreach (ev[s]) begin
            ev[s] = 1'b0;
            es[s] = 1'b0;
        end
        forever begin
            @(posedge clk);
            e++;
            if (rst) begin
                for (int d = 0; d < 8; d++) begin
                    ev[(e + d) % 16] = 1'b0;
                    es[(e + d) % 16] = 1'b0;
                end
                msat  = 1'b0;
                fills = 0;
                for (int k = 0; k < NT; k++) begin
                    mshadow[k] = 0;
                    mactive[k] = 0;
                end
            end else begin
                if (ev[e % 16] && es[e % 16])
                    msat = 1'b1;
                ev[(e + 7) % 16] = 1'b0;
                es[(e + 7) % 16] = 1'b0;
                if (bus.taps_vld) begin
                    if (fills >= BL / U - 1) begin
                        for (int i = 0; i < U; i++) begin
                            longint y;
                            longint r;
                            y = 0;
                            for (int k = 0; k < NT; k++) begin
                                int t;
                                t = $signed(bus.taps[i + k]);
                                y += longint'(mactive[k]) * longint'(t);
                            end
                            r = (y + 16384) >>> 15;
                            if (r > 32767) begin
                                r = 32767;
                                es[(e + 7) % 16] = 1'b1;
                            end else if (r < -32768) begin
                                r = -32768;
                                es[(e + 7) % 16] = 1'b1;
                            end
                            ed[(e + 7) % 16][i] = r;
                        end
                        ev[(e + 7) % 16] = 1'b1;
                    end
                    if (fills < BL / U)
                        fills++;
                end
                if (bus.coef_we && bus.coef_addr < 6'(NT))
                    mshadow[bus.coef_addr] = int'($signed(bus.coef_data));
                if (bus.coef_commit)
                    mactive = mshadow;
            end
        end
    end

    // Compare process: every cycle, away from the rising edge.
    initial begin
        forever begin
            int s;
            @(negedge clk);
            if (e > 0) begin
                s = e % 16;
                check("dout_vld", longint'(bus.dout_vld), longint'(ev[s]));
                check("sat_flag", longint'(bus.sat_flag), longint'(msat));
                if (bus.dout_vld) begin
                    for (int i = 0; i < U; i++) begin
                        got.push_back(int'($signed(bus.dout[i])));
                        if (ev[s])
                            check($sformatf("dout[%0d]", i), longint'($signed(bus.dout[i])), ed[s][i]);
                    end
                end
            end
        end
    end

    initial begin
        int  n;
        bit  found;
        int  bad;

        rst = 1'b1;
        bus.taps_vld    = 1'b0;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_data   = '0;
        bus.coef_commit = 1'b0;
        set_taps(0);
        for (int j = 0; j < BL; j++)
            bus.taps[j] = '0;

        // 1: reset held three clocks with random stimulus, then released.
        for (int c = 0; c < 5; c++) begin
            rand_taps();
            cyc(c < 3 ? 1'($urandom_range(1)) : 1'b0, 1'b0, 0, 0, 1'b0, c < 3);
            check("rst_dout", longint'(bus.dout), 0);
            check("rst_dout_vld", longint'(bus.dout_vld), 0);
            check("rst_sat_flag", longint'(bus.sat_flag), 0);
        end

        // 2: warm-up with DC input and flat coefficients.
        load(0, 16384);
        set_taps(1000);
        repeat (10) cyc(1'b1);
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            cyc(1'b1);
            n++;
            found = bus.dout_vld;
        end
        check("warmup_latency", found ? n : -1, 8);
        for (int i = 0; i < U; i++)
            check("warmup_dc", longint'($signed(bus.dout[i])), 18500);
        drain();

        // 3: ramp coefficients, impulse of 8192 stepped through the window.
        load(1, 0);
        drain();
        got.delete();
        for (int j = 0; j < BL; j++) begin
            set_taps(0);
            tv[j] = 8192;
            cyc(1'b1);
        end
        set_taps(0);
        drain();
        check("impulse_count", got.size(), BL * U);
        check("impulse_j0_l0", got[0], 0);
        check("impulse_j1_l0", got[4 * 1 + 0], 25);
        check("impulse_j36_l0", got[4 * 36 + 0], 900);
        check("impulse_j37_l0", got[4 * 37 + 0], 0);
        check("impulse_j39_l3", got[4 * 39 + 3], 900);

        // 4: positive then negative saturation.
        load(0, 32767);
        drain();
        got.delete();
        set_taps(16383);
        repeat (3) cyc(1'b1);
        set_taps(0);
        repeat (3) cyc(1'b1);
        drain();
        check("sat_pos_l0", got[0], 32767);
        check("sat_pos_l3", got[3], 32767);
        check("sat_after_zero", got[4 * 3 + 0], 0);
        check("sat_sticky", longint'(bus.sat_flag), 1);
        got.delete();
        set_taps(-16384);
        repeat (3) cyc(1'b1);
        set_taps(0);
        drain();
        check("sat_neg_l0", got[0], -32768);
        check("sat_neg_l3", got[4 * 2 + 3], -32768);

        // 5: coefficient switch while streaming; commit on group 40.
        load(0, 16384);
        drain();
        got.delete();
        set_taps(1000);
        for (int t = 0; t < 50; t++) begin
            if (t < NT)       cyc(1'b1, 1'b1, t, 8192);
            else if (t == 37) cyc(1'b1, 1'b1, 40, 1);
            else if (t == 38) cyc(1'b1, 1'b1, 63, 1);
            else if (t == 40) cyc(1'b1, 1'b0, 0, 0, 1'b1);
            else              cyc(1'b1);
        end
        drain();
        bad = 0;
        for (int m = 0; m < 50; m++)
            for (int i = 0; i < U; i++)
                if (m * U + i < got.size() && got[m * U + i] != ((m <= 40) ? 18500 : 9250))
                    bad++;
        check("commit_count", got.size(), 50 * U);
        check("commit_mixed", bad, 0);
        check("commit_edge", got[41 * U], 9250);

        // 6: random bubbles, resets mid-run and mid-fill.
        load(2, 0);
        for (int t = 0; t < 150; t++) begin
            rand_taps();
            cyc($urandom_range(2) != 0, 1'b0, 0, 0, 1'b0, t == 80);
        end
        load(2, 0);
        for (int t = 0; t < 120; t++) begin
            rand_taps();
            cyc($urandom_range(2) != 0, 1'b0, 0, 0, 1'b0, t == 25);
        end
        load(2, 0);
        for (int t = 0; t < 80; t++) begin
            rand_taps();
            cyc($urandom_range(3) != 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
